// File: rtl/adc_filt_pkg.sv
// adc_filt_pkg: shared widths and constants for the ADC sample filter
package adc_filt_pkg;
    localparam int ADC_BITS = 8;
    localparam int VOLT_BITS = 9;
    localparam int VREF_CV_DEFAULT = 330;
    function automatic int sum_width(input int depth_log2);
        return depth_log2 + ADC_BITS;
    endfunction
endpackage

// File: rtl/adc_sample_filter_if.sv
// adc_sample_filter_if: sample strobe in, filtered results out
interface adc_sample_filter_if;
    import adc_filt_pkg::*;
    logic sample_valid;
    logic [ADC_BITS-1:0] sample;
    logic clear;
    logic [ADC_BITS-1:0] avg;
    logic [VOLT_BITS-1:0] volt_cv;
    logic avg_valid;
    logic [ADC_BITS-1:0] min_s;
    logic [ADC_BITS-1:0] max_s;
    logic filled;
    modport master(output sample_valid, sample, clear, input avg, volt_cv, avg_valid, min_s, max_s, filled);
    modport slave(input sample_valid, sample, clear, output avg, volt_cv, avg_valid, min_s, max_s, filled);
endinterface

// File: rtl/adc_sample_ring.sv
// adc_sample_ring: 2^DEPTH_LOG2 byte ring; the slot about to be overwritten is readable combinationally
module adc_sample_ring import adc_filt_pkg::*; #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                we,
    input  logic [ADC_BITS-1:0] wdata,
    output logic [ADC_BITS-1:0] rdata
);
    logic [ADC_BITS-1:0] mem [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    assign rdata = mem[wr_ptr];
    always_ff @(posedge clk) begin
        if (!rst_n || clear) wr_ptr <= '0;
        else if (we) wr_ptr <= wr_ptr + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/adc_sample_filter.sv
// adc_sample_filter: 2^K moving average with centivolt scaling and running min/max
module adc_sample_filter import adc_filt_pkg::*; #(
    parameter int DEPTH_LOG2 = 3,
    parameter int VREF_CV = VREF_CV_DEFAULT
) (
    input logic clk,
    input logic rst_n,
    adc_sample_filter_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SW = sum_width(DEPTH_LOG2);
    localparam int CW = DEPTH_LOG2 + 1;
    logic [CW-1:0] cnt;
    logic [SW-1:0] sum;
    logic [SW-1:0] old;
    logic [ADC_BITS-1:0] rdata;
    logic [ADC_BITS-1:0] avg_next;
    logic [VOLT_BITS-1:0] volt_next;
    logic take;
    logic full;
    logic s1;
    assign take = bus.sample_valid && !bus.clear;
    assign full = cnt == CW'(DEPTH);
    // stale ring bytes are masked until the window has been filled once
    assign old = full ? SW'(rdata) : '0;
    assign avg_next = sum[SW-1:DEPTH_LOG2];
    assign volt_next = VOLT_BITS'((17'(avg_next) * 17'(VREF_CV)) >> 8);
    adc_sample_ring #(.DEPTH_LOG2(DEPTH_LOG2)) u_ring (
        .clk(clk),
        .rst_n(rst_n),
        .clear(bus.clear),
        .we(take && rst_n),
        .wdata(bus.sample),
        .rdata(rdata)
    );
    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear) begin
            cnt <= '0;
            sum <= '0;
            s1 <= 1'b0;
            bus.min_s <= '1;
            bus.max_s <= '0;
            bus.filled <= 1'b0;
            bus.avg_valid <= 1'b0;
        end else begin
            s1 <= take;
            bus.avg_valid <= s1 && full;
            if (s1 && full) begin
                bus.avg <= avg_next;
                bus.volt_cv <= volt_next;
            end
            if (take) begin
                sum <= sum + SW'(bus.sample) - old;
                cnt <= full ? cnt : cnt + 1'b1;
                bus.filled <= cnt >= CW'(DEPTH - 1);
                if (bus.sample < bus.min_s) bus.min_s <= bus.sample;
                if (bus.sample > bus.max_s) bus.max_s <= bus.sample;
            end
        end
        if (!rst_n) begin
            bus.avg <= '0;
            bus.volt_cv <= '0;
        end
    end
endmodule

// File: tb/tb_adc_sample_filter.sv
// tb_adc_sample_filter: queue-based window model checked every cycle, plus directed literal checks
module tb_adc_sample_filter;
    localparam int DEPTH = 8;
    localparam int VREF = 330;
    logic clk = 0;
    logic rst_n = 0;
    adc_sample_filter_if bus();
    adc_sample_filter #(.DEPTH_LOG2(3), .VREF_CV(VREF)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    int n_checks = 0;
    int n_err = 0;
    bit chk_en = 0;
    bit rec = 0;
    int pulses[$];
    int hist[$];
    bit m_pend = 0;
    int m_pavg = 0;
    bit m_av = 0;
    int m_avg = 0;
    int m_volt = 0;
    int m_min = 255;
    int m_max = 0;
    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask
    // model: window = last DEPTH accepted samples since reset/clear; result appears two edges after the strobe
    always @(posedge clk) begin
        if (!rst_n) begin
            hist.delete();
            m_pend = 0; m_av = 0; m_avg = 0; m_volt = 0; m_min = 255; m_max = 0;
        end else if (bus.clear) begin
            hist.delete();
            m_pend = 0; m_av = 0; m_min = 255; m_max = 0;
        end else begin
            m_av = m_pend;
            if (m_pend) begin
                m_avg = m_pavg;
                m_volt = m_pavg * VREF / 256;
            end
            m_pend = 0;
            if (bus.sample_valid) begin
                int s;
                hist.push_back(int'(bus.sample));
                if (int'(bus.sample) < m_min) m_min = int'(bus.sample);
                if (int'(bus.sample) > m_max) m_max = int'(bus.sample);
                if (hist.size() >= DEPTH) begin
                    s = 0;
                    for (int k = hist.size() - DEPTH; k < hist.size(); k++) s += hist[k];
                    m_pavg = s / DEPTH;
                    m_pend = 1;
                end
            end
        end
    end
    always @(negedge clk) begin
        if (chk_en) begin
            check("avg_valid", int'(bus.avg_valid), int'(m_av));
            check("avg", int'(bus.avg), m_avg);
            check("volt_cv", int'(bus.volt_cv), m_volt);
            check("min_s", int'(bus.min_s), m_min);
            check("max_s", int'(bus.max_s), m_max);
            check("filled", int'(bus.filled), int'(hist.size() >= DEPTH));
            if (rec && bus.avg_valid) pulses.push_back(int'(bus.avg));
        end
    end
    task automatic strobe(input logic [7:0] s);
        @(negedge clk);
        bus.sample_valid = 1; bus.sample = s;
        @(negedge clk);
        bus.sample_valid = 0;
    endtask
    task automatic do_clear();
        @(negedge clk);
        bus.clear = 1;
        @(negedge clk);
        bus.clear = 0;
    endtask
    initial begin
        bus.sample_valid = 0; bus.sample = 0; bus.clear = 0;
        repeat (3) @(negedge clk);
        check("rst_avg", int'(bus.avg), 0);
        check("rst_volt", int'(bus.volt_cv), 0);
        check("rst_av", int'(bus.avg_valid), 0);
        check("rst_min", int'(bus.min_s), 255);
        check("rst_max", int'(bus.max_s), 0);
        check("rst_filled", int'(bus.filled), 0);
        rst_n = 1;
        chk_en = 1;
        for (int i = 0; i < 8; i++) begin
            strobe(8'h80);
            check("fill_filled", int'(bus.filled), i == 7 ? 1 : 0);
            if (i < 7) repeat (100) @(negedge clk);
        end
        @(negedge clk);
        check("fill_av", int'(bus.avg_valid), 1);
        check("fill_avg", int'(bus.avg), 128);
        check("fill_volt", int'(bus.volt_cv), 165);
        do_clear();
        for (int i = 0; i < 8; i++) strobe(8'h00);
        strobe(8'hFF);
        @(negedge clk);
        check("slide1_avg", int'(bus.avg), 31);
        check("slide1_volt", int'(bus.volt_cv), 39);
        for (int i = 0; i < 7; i++) strobe(8'hFF);
        @(negedge clk);
        check("slide8_avg", int'(bus.avg), 255);
        check("slide8_volt", int'(bus.volt_cv), 328);
        do_clear();
        pulses.delete();
        rec = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.sample_valid = 1; bus.sample = 8'(i);
        end
        @(negedge clk);
        bus.sample_valid = 0;
        repeat (4) @(negedge clk);
        rec = 0;
        check("b2b_pulses", pulses.size(), 9);
        for (int i = 0; i < 9 && i < pulses.size(); i++) check("b2b_avg", pulses[i], 3 + i);
        do_clear();
        strobe(8'h40); strobe(8'h10); strobe(8'hC0);
        @(negedge clk);
        check("mm_min", int'(bus.min_s), 16);
        check("mm_max", int'(bus.max_s), 192);
        check("mm_av", int'(bus.avg_valid), 0);
        do_clear();
        for (int i = 0; i < 8; i++) strobe(8'h20);
        @(negedge clk);
        check("pre_clr_avg", int'(bus.avg), 32);
        bus.sample_valid = 1; bus.sample = 8'hAA; bus.clear = 1;
        @(negedge clk);
        bus.sample_valid = 0; bus.clear = 0;
        check("clr_min", int'(bus.min_s), 255);
        check("clr_max", int'(bus.max_s), 0);
        check("clr_filled", int'(bus.filled), 0);
        check("clr_avg_hold", int'(bus.avg), 32);
        for (int i = 0; i < 7; i++) strobe(8'h55);
        @(negedge clk);
        check("refill7_av", int'(bus.avg_valid), 0);
        strobe(8'h55);
        @(negedge clk);
        check("refill8_av", int'(bus.avg_valid), 1);
        check("refill8_avg", int'(bus.avg), 85);
        check("refill8_volt", int'(bus.volt_cv), 109);
        strobe(8'h11);
        bus.clear = 1;
        @(negedge clk);
        bus.clear = 0;
        check("inflight_av", int'(bus.avg_valid), 0);
        check("inflight_avg", int'(bus.avg), 85);
        do_clear();
        for (int i = 0; i < 5; i++) strobe(8'h30);
        bus.sample_valid = 1; bus.sample = 8'h31;
        @(negedge clk);
        rst_n = 0;
        bus.sample_valid = 1; bus.sample = 8'h32;
        @(negedge clk);
        bus.sample_valid = 0;
        check("mrst_avg", int'(bus.avg), 0);
        check("mrst_volt", int'(bus.volt_cv), 0);
        check("mrst_av", int'(bus.avg_valid), 0);
        check("mrst_min", int'(bus.min_s), 255);
        check("mrst_max", int'(bus.max_s), 0);
        check("mrst_filled", int'(bus.filled), 0);
        rst_n = 1;
        for (int i = 0; i < 8; i++) strobe(8'h10);
        @(negedge clk);
        check("post_rst_avg", int'(bus.avg), 16);
        check("post_rst_volt", int'(bus.volt_cv), 20);
        repeat (3) @(negedge clk);
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
